// File: rtl/fp32_mul_sequencer_if.sv
// Handshake and data bundle for fp32_mul_sequencer.
//   in_valid/in_ready/a/b        : operand channel (source -> unit)
//   out_valid/out_ready/result   : result channel (unit -> consumer)
//   flag_*                       : exception flags, qualified by out_valid
// The unit itself connects through the slave modport; the master modport
// is the view seen by the operand source / result consumer.
interface fp32_mul_sequencer_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        flag_invalid;
    logic        flag_overflow;
    logic        flag_underflow;
    logic        flag_inexact;

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, result,
               flag_invalid, flag_overflow, flag_underflow, flag_inexact
    );

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, result,
               flag_invalid, flag_overflow, flag_underflow, flag_inexact
    );
endinterface

// File: rtl/fp32_mul_sequencer.sv
// Sequenced IEEE-754 single-precision multiplier.
// Operands are classified, the 24x24 mantissa product is built one multiplier
// bit per cycle on a 48-bit accumulator, then normalized, rounded to
// nearest-even and packed. Denormal inputs are treated as signed zero and
// tiny results are flushed to signed zero.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous reset, active-high
//   bus  - fp32_mul_sequencer_if.slave (operand/result handshakes and flags)
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | in_ready=1, waiting for an operand pair
// CLASSIFY | decode operands; specials resolved here and go straight to DONE
// MULT     | 24 shift-add steps on the accumulator
// NORM     | pick the 23-bit fraction, guard and sticky from the product
// ROUND    | round to nearest-even, detect overflow/underflow, pack
// DONE     | result held; out_valid rises one cycle after entry
module fp32_mul_sequencer #(
    parameter int          MUL_ITERS = 24,
    parameter logic [31:0] QNAN      = 32'h7FC00000
) (
    input logic             clk,
    input logic             rst,
    fp32_mul_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE, CLASSIFY, MULT, NORM, ROUND, DONE
    } state_t;

    localparam logic [4:0] LAST_ITER = 5'(MUL_ITERS - 1);

    state_t state, state_n;

    logic [31:0] a_q, b_q;
    logic        sign_q;
    logic [23:0] mcand_q, mplier_q;
    logic [47:0] acc_q;
    logic [4:0]  cnt_q;
    logic signed [9:0] exp_q;
    logic [22:0] mant_q;
    logic        guard_q, sticky_q;
    logic [31:0] result_q;
    logic        inv_q, ovf_q, unf_q, inx_q;
    logic        out_valid_q;

    // operand classification
    logic [7:0] ea, eb;
    logic       a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, special;
    assign ea      = a_q[30:23];
    assign eb      = b_q[30:23];
    assign a_zero  = (ea == 8'h00);
    assign b_zero  = (eb == 8'h00);
    assign a_inf   = (ea == 8'hFF) && (a_q[22:0] == 23'd0);
    assign b_inf   = (eb == 8'hFF) && (b_q[22:0] == 23'd0);
    assign a_nan   = (ea == 8'hFF) && (a_q[22:0] != 23'd0);
    assign b_nan   = (eb == 8'hFF) && (b_q[22:0] != 23'd0);
    assign special = a_zero || b_zero || a_inf || b_inf || a_nan || b_nan;

    logic signed [9:0] exp_sum;
    assign exp_sum = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;

    // rounding
    logic              rnd_inc;
    logic [23:0]       mant_rnd;
    logic signed [9:0] exp_rnd;
    logic [22:0]       frac_rnd;
    logic              rnd_ovf, rnd_unf;
    assign rnd_inc  = guard_q && (sticky_q || mant_q[0]);
    assign mant_rnd = {1'b0, mant_q} + {23'd0, rnd_inc};
    // carry-out of the fraction bumps the exponent; fraction becomes zero
    assign exp_rnd  = mant_rnd[23] ? (exp_q + 10'sd1) : exp_q;
    assign frac_rnd = mant_rnd[23] ? 23'd0 : mant_rnd[22:0];
    assign rnd_ovf  = (exp_rnd >= 10'sd255);
    assign rnd_unf  = (exp_rnd <= 10'sd0);

    logic accept, handoff;
    assign accept  = bus.in_valid && (state == IDLE);
    assign handoff = out_valid_q && bus.out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:     if (accept) state_n = CLASSIFY;
            CLASSIFY: state_n = special ? DONE : MULT;
            MULT:     if (cnt_q == LAST_ITER) state_n = NORM;
            NORM:     state_n = ROUND;
            ROUND:    state_n = DONE;
            DONE:     if (handoff) state_n = IDLE;
            default:  state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q         <= '0;
            b_q         <= '0;
            sign_q      <= 1'b0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            exp_q       <= '0;
            mant_q      <= '0;
            guard_q     <= 1'b0;
            sticky_q    <= 1'b0;
            result_q    <= '0;
            inv_q       <= 1'b0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            inx_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_q <= bus.a;
                        b_q <= bus.b;
                    end
                end
                CLASSIFY: begin
                    sign_q   <= a_q[31] ^ b_q[31];
                    mcand_q  <= {1'b1, a_q[22:0]};
                    mplier_q <= {1'b1, b_q[22:0]};
                    exp_q    <= exp_sum;
                    acc_q    <= '0;
                    cnt_q    <= '0;
                    inv_q    <= 1'b0;
                    ovf_q    <= 1'b0;
                    unf_q    <= 1'b0;
                    inx_q    <= 1'b0;
                    if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) begin
                        result_q <= QNAN;
                        inv_q    <= 1'b1;
                    end else if (a_inf || b_inf) begin
                        result_q <= {a_q[31] ^ b_q[31], 8'hFF, 23'd0};
                    end else begin
                        result_q <= {a_q[31] ^ b_q[31], 31'd0};
                    end
                end
                MULT: begin
                    if (mplier_q[cnt_q])
                        acc_q <= acc_q + ({24'd0, mcand_q} << cnt_q);
                    cnt_q <= cnt_q + 5'd1;
                end
                NORM: begin
                    if (acc_q[47]) begin
                        mant_q   <= acc_q[46:24];
                        exp_q    <= exp_q + 10'sd1;
                        guard_q  <= acc_q[23];
                        sticky_q <= |acc_q[22:0];
                    end else begin
                        mant_q   <= acc_q[45:23];
                        guard_q  <= acc_q[22];
                        sticky_q <= |acc_q[21:0];
                    end
                end
                ROUND: begin
                    if (rnd_ovf) begin
                        result_q <= {sign_q, 8'hFF, 23'd0};
                        ovf_q    <= 1'b1;
                        inx_q    <= 1'b1;
                    end else if (rnd_unf) begin
                        result_q <= {sign_q, 31'd0};
                        unf_q    <= 1'b1;
                        inx_q    <= 1'b1;
                    end else begin
                        result_q <= {sign_q, exp_rnd[7:0], frac_rnd};
                        inx_q    <= guard_q | sticky_q;
                    end
                end
                DONE: begin
                    // first DONE cycle raises out_valid; handoff drops it
                    out_valid_q <= !handoff;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready       = (state == IDLE);
    assign bus.out_valid      = out_valid_q;
    assign bus.result         = result_q;
    assign bus.flag_invalid   = inv_q;
    assign bus.flag_overflow  = ovf_q;
    assign bus.flag_underflow = unf_q;
    assign bus.flag_inexact   = inx_q;
endmodule

// File: tb/tb_fp32_mul_sequencer.sv
// Self-checking bench for fp32_mul_sequencer: directed vector table,
// randomized operands against an arithmetic reference model, and hand-built
// backpressure and mid-operation reset sequences.
module tb_fp32_mul_sequencer;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    fp32_mul_sequencer_if bus();

    fp32_mul_sequencer #(.MUL_ITERS(24), .QNAN(32'h7FC00000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [3:0]  flags;   // {invalid, overflow, underflow, inexact}
        int          lat;
    } vec_t;

    task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", name, got, exp);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic logic [3:0] dut_flags();
        return {bus.flag_invalid, bus.flag_overflow, bus.flag_underflow, bus.flag_inexact};
    endfunction

    // Reference: exact integer product of the significands, then round to
    // nearest-even by comparing the discarded remainder with one half ulp.
    function automatic logic [35:0] model(input logic [31:0] x, input logic [31:0] y);
        logic        s;
        int          ex, ey, e, sh;
        logic        nx, ny, ix, iy, zx, zy;
        longint      mx, my, p, m, rem, half;
        logic [31:0] r;
        logic [3:0]  f;
        s  = x[31] ^ y[31];
        ex = int'(x[30:23]);
        ey = int'(y[30:23]);
        nx = (ex == 255) && (x[22:0] != 0);
        ny = (ey == 255) && (y[22:0] != 0);
        ix = (ex == 255) && (x[22:0] == 0);
        iy = (ey == 255) && (y[22:0] == 0);
        zx = (ex == 0);
        zy = (ey == 0);
        f  = 4'b0000;
        if (nx || ny || (ix && zy) || (zx && iy)) begin
            r = 32'h7FC00000;
            f = 4'b1000;
        end else if (ix || iy) begin
            r = {s, 8'hFF, 23'd0};
        end else if (zx || zy) begin
            r = {s, 31'd0};
        end else begin
            mx = 0;
            my = 0;
            mx[23:0] = {1'b1, x[22:0]};
            my[23:0] = {1'b1, y[22:0]};
            p  = mx * my;
            e  = ex + ey - 127;
            sh = 23;
            if (p >= (longint'(1) << 47)) begin
                sh = 24;
                e  = e + 1;
            end
            m    = p >> sh;
            rem  = p - (m << sh);
            half = longint'(1) << (sh - 1);
            if (rem > half || (rem == half && m[0])) m = m + 1;
            if (m == (longint'(1) << 24)) begin
                m = longint'(1) << 23;
                e = e + 1;
            end
            if (e >= 255) begin
                r = {s, 8'hFF, 23'd0};
                f = 4'b0101;
            end else if (e <= 0) begin
                r = {s, 31'd0};
                f = 4'b0011;
            end else begin
                r = {s, 8'(e), m[22:0]};
                f[0] = (rem != 0);
            end
        end
        return {r, f};
    endfunction

    // Launch one operation and wait for out_valid; lat counts rising edges
    // from the accepting edge to the edge that raised out_valid.
    task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic early_ready,
                          output logic [31:0] r, output logic [3:0] f, output int lat);
        int guard;
        @(negedge clk);
        guard = 0;
        while (!bus.in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!bus.in_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL in_ready_timeout: got 0 expected 1");
        end
        bus.in_valid  = 1'b1;
        bus.a         = x;
        bus.b         = y;
        bus.out_ready = early_ready;
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        if (!bus.out_valid) begin
            n_cmp++;
            n_bad++;
            $display("FAIL out_valid_timeout: got 0 expected 1");
        end
        r = bus.result;
        f = dut_flags();
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    vec_t        vecs[$];
    logic [31:0] r;
    logic [3:0]  f;
    int          lat;
    logic [35:0] m;
    logic [31:0] x, y;

    initial begin
        n_cmp = 0;
        n_bad = 0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        rst = 1'b1;
        #1;
        check_int("reset_in_ready", int'(bus.in_ready), 1);
        check_int("reset_out_valid", int'(bus.out_valid), 0);
        check32("reset_result", bus.result, 32'h0);
        check_int("reset_flags", int'(dut_flags()), 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        vecs.push_back('{32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000, 28});
        vecs.push_back('{32'hC0000000, 32'h40400000, 32'hC0C00000, 4'b0000, 28});
        vecs.push_back('{32'h3F800000, 32'h3F800000, 32'h3F800000, 4'b0000, 28});
        vecs.push_back('{32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001, 28});
        vecs.push_back('{32'h7F000000, 32'h7F000000, 32'h7F800000, 4'b0101, 28});
        vecs.push_back('{32'h00800000, 32'h00800000, 32'h00000000, 4'b0011, 28});
        vecs.push_back('{32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000, 2});
        vecs.push_back('{32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'b1000, 2});
        vecs.push_back('{32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000, 2});
        vecs.push_back('{32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE, 4'b0001, 28});
        vecs.push_back('{32'h80000000, 32'h3F800000, 32'h80000000, 4'b0000, 2});

        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, logic'(i % 2), r, f, lat);
            check32($sformatf("vec%0d_result", i), r, vecs[i].res);
            check_int($sformatf("vec%0d_flags", i), int'(f), int'(vecs[i].flags));
            check_int($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
        end

        for (int i = 0; i < 200; i++) begin
            if (i % 4 == 0) begin
                x = $urandom;
                y = $urandom;
            end else begin
                x = {1'($urandom), 8'($urandom_range(90, 165)), 23'($urandom)};
                y = {1'($urandom), 8'($urandom_range(90, 165)), 23'($urandom)};
            end
            m = model(x, y);
            run_op(x, y, 1'b0, r, f, lat);
            check32($sformatf("rand%0d_result(%08h*%08h)", i, x, y), r, m[35:4]);
            check_int($sformatf("rand%0d_flags", i), int'(f), int'(m[3:0]));
        end

        // Backpressure: hold the result in DONE while new operands are offered.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.a = 32'h3FC00000;
        bus.b = 32'h40000000;
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check_int("bp_latency", lat, 28);
        bus.in_valid = 1'b1;
        bus.a = 32'h40000000;
        bus.b = 32'h40000000;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check32("bp_result_stable", bus.result, 32'h40400000);
            check_int("bp_out_valid_held", int'(bus.out_valid), 1);
            check_int("bp_in_ready_low", int'(bus.in_ready), 0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check_int("bp_out_valid_dropped", int'(bus.out_valid), 0);
        check_int("bp_in_ready_back", int'(bus.in_ready), 1);
        repeat (3) @(negedge clk);
        check_int("bp_no_stray_result", int'(bus.out_valid), 0);

        // Reset during the multiply abandons the operation.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.a = 32'h3F800000;
        bus.b = 32'h40400000;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (11) @(negedge clk);
        rst = 1'b1;
        #1;
        check_int("rst_mid_out_valid", int'(bus.out_valid), 0);
        check_int("rst_mid_in_ready", int'(bus.in_ready), 1);
        @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        check_int("rst_mid_no_output", int'(bus.out_valid), 0);
        run_op(32'h3F800000, 32'h40400000, 1'b0, r, f, lat);
        check32("post_rst_result", r, 32'h40400000);
        check_int("post_rst_flags", int'(f), 0);
        check_int("post_rst_latency", lat, 28);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
